tx_control: RTL and testbench
=============================

# tx_control

Transmit-side sequencer for the UART calculator path. On a one-cycle `trigger` from the receive/command controller it snapshots the 16-bit ALU result (and optionally the ALU flags) and serialises it as bytes, LSB first, into the UART transmitter through a start/busy handshake. It sits between the ALU output and the UART TX core and mirrors the receive sequencer's byte ordering.

## Interface
- `SEND_FLAGS`, default 0: when 1, a third byte `{3'b000, flags}` is sent after the MSB.
- `clk`  input  1  system clock (100 MHz).
- `reset`  input  1  asynchronous, active-high reset.
- `trigger`  input  1  one-cycle request to send the current result.
- `alu_result`  input  16  result word, sampled only on an accepted trigger.
- `alu_flags`  input  5  ALU flags, sampled with `alu_result`.
- `tx_busy`  input  1  UART TX busy. Rises some cycles after `tx_start` and falls when the frame completes.
- `tx_start`  output  1  one-cycle start strobe to the UART TX.
- `tx_data`  output  8  byte to transmit. Stable from the `tx_start` cycle until that byte's wait completes.
- `busy`  output  1  high whenever the sequencer is not in Idle.
- `done`  output  1  one-cycle pulse after the last byte has completed.
- `dropped`  output  1  sticky: a trigger arrived while `busy` was high. Cleared only by reset.
- `leds`  output  8  one-hot state indicator. Bit index = state index below.

## Operation
- States (index):
  - Idle (0): on `trigger`, capture `alu_result` and `alu_flags` into shadow registers and go to Send_LSB. Otherwise stay.
  - Send_LSB (1): `tx_data = shadow[7:0]`. If `tx_busy` = 0, assert `tx_start` (combinational in this state) and go to Wait_LSB. Otherwise hold.
  - Wait_LSB (2): set a `seen_busy` flop when `tx_busy` = 1. When `seen_busy` is set and `tx_busy` = 0, clear `seen_busy` and go to Send_MSB.
  - Send_MSB (3) / Wait_MSB (4): same behaviour for `shadow[15:8]`. Wait_MSB exits to Send_FLG if `SEND_FLAGS` = 1, else to Done.
  - Send_FLG (5) / Wait_FLG (6): same behaviour for `{3'b000, flags}`. Wait_FLG exits to Done.
  - Done (7): `done` = 1 for one cycle, then go to Idle.
  - Undefined encoding: go to Idle with all strobes low.
- Shadow registers are written only in Idle on `trigger`. Later changes on `alu_result` do not affect a transfer in progress.
- A trigger in any state other than Idle is ignored and sets `dropped`. A trigger in the Done cycle is also dropped.
- `tx_data` is registered from the shadow by byte index. Outside the Send/Wait states it holds its last value.
- `tx_start` is never high for two consecutive cycles and is never high while `tx_busy` = 1.

## Timing
- Reset values: state Idle, shadows 0, `seen_busy` 0, `tx_start` 0, `tx_data` 0x00, `busy` 0, `done` 0, `dropped` 0, `leds` 8'h01.
- Reset is asynchronous: asserting it mid-transfer returns the block to Idle immediately, `tx_start` drops in the same cycle, and no `done` is produced.
- Trigger accepted at edge N → state Send_LSB in cycle N+1. If `tx_busy` = 0, `tx_start` is high in cycle N+1 with `tx_data` = LSB already valid.
- Send → Wait takes 1 cycle. Wait exits on the first edge where `seen_busy` is set and `tx_busy` = 0. The next Send state can strobe in the following cycle.
- If `tx_busy` is high on entry to Send_LSB (UART still finishing an earlier frame), `tx_start` is delayed until `tx_busy` falls.
- Wait states have no timeout. If `tx_busy` never rises, the block waits until reset (verification must check that the sequencer stays in the Wait state).
- `done` is high in the cycle after the last Wait exit. `busy` falls in the cycle after `done`.

## Test plan
- Basic two-byte send: result 0xA55A, `SEND_FLAGS` = 0, UART model busy for 10 cycles starting 2 cycles after each start → exactly two `tx_start` pulses carrying 0x5A then 0xA5, then one `done`, then `busy` = 0. `dropped` stays 0.
- Flags byte: `SEND_FLAGS` = 1, result 0x0100, flags 5'b10011 → bytes 0x00, 0x01, 0x13 in that order, then `done`.
- Snapshot and overlap: change `alu_result` to 0xFFFF and pulse `trigger` during Wait_LSB of a 0x1234 transfer → bytes 0x34 and 0x12 only, `dropped` = 1, single `done`.
- Busy at start: hold `tx_busy` = 1 for 5 cycles after the trigger → `tx_start` stays low until the cycle `tx_busy` is 0, and `leds` = 8'h02 throughout.
- Reset mid-operation: assert `reset` in Wait_MSB → `leds` = 8'h01, no `done`. After release, a new trigger with 0xBEEF sends 0xEF then 0xBE.
- Back-to-back: a trigger the cycle after `busy` falls is accepted (no drop) and the sequence repeats correctly; `tx_start` is never high while `tx_busy` = 1 (assertion).

Source files
------------

// File: rtl/tx_control.sv
// tx_control: transmit-side sequencer. Snapshots the ALU result (and optionally
// the flags) on a trigger and hands it byte by byte, LSB first, to the UART TX
// through a start/busy handshake.
module tx_control #(
  parameter bit SEND_FLAGS = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [15:0] alu_result,
  input  logic [4:0]  alu_flags,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done,
  output logic        dropped,
  output logic [7:0]  leds
);

  // Encodings double as the leds bit index.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSendLsb = 3'd1,
    StWaitLsb = 3'd2,
    StSendMsb = 3'd3,
    StWaitMsb = 3'd4,
    StSendFlg = 3'd5,
    StWaitFlg = 3'd6,
    StDone    = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] shadow_q, shadow_d;
  logic [4:0]  flags_q, flags_d;
  logic        seen_busy_q, seen_busy_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        dropped_q, dropped_d;
  logic        wait_exit;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shadow_q    <= 16'h0000;
      flags_q     <= 5'h00;
      seen_busy_q <= 1'b0;
      tx_data_q   <= 8'h00;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      flags_q     <= flags_d;
      seen_busy_q <= seen_busy_d;
      tx_data_q   <= tx_data_d;
      dropped_q   <= dropped_d;
    end
  end

  // A byte's wait ends only after the UART has been seen busy and then idle again.
  assign wait_exit = seen_busy_q && !tx_busy;

  // Next-state logic and per-state strobes.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    flags_d     = flags_q;
    seen_busy_d = seen_busy_q;
    tx_start    = 1'b0;
    done        = 1'b0;
    case (state_q)
      StIdle: begin
        seen_busy_d = 1'b0;
        if (trigger) begin
          shadow_d = alu_result;
          flags_d  = alu_flags;
          state_d  = StSendLsb;
        end
      end
      StSendLsb: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = StWaitLsb;
        end
      end
      StWaitLsb: begin
        if (wait_exit) begin
          seen_busy_d = 1'b0;
          state_d     = StSendMsb;
        end else if (tx_busy) begin
          seen_busy_d = 1'b1;
        end
      end
      StSendMsb: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = StWaitMsb;
        end
      end
      StWaitMsb: begin
        if (wait_exit) begin
          seen_busy_d = 1'b0;
          state_d     = SEND_FLAGS ? StSendFlg : StDone;
        end else if (tx_busy) begin
          seen_busy_d = 1'b1;
        end
      end
      StSendFlg: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = StWaitFlg;
        end
      end
      StWaitFlg: begin
        if (wait_exit) begin
          seen_busy_d = 1'b0;
          state_d     = StDone;
        end else if (tx_busy) begin
          seen_busy_d = 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d     = StIdle;
        seen_busy_d = 1'b0;
      end
    endcase
  end

  // Load tx_data on entry to a Send state so the byte is valid with the first strobe.
  always_comb begin
    tx_data_d = tx_data_q;
    case (state_d)
      StSendLsb: tx_data_d = shadow_d[7:0];
      StSendMsb: tx_data_d = shadow_d[15:8];
      StSendFlg: tx_data_d = {3'b000, flags_d};
      default:   tx_data_d = tx_data_q;
    endcase
  end

  // Any trigger outside Idle (Done included) is lost and remembered until reset.
  always_comb begin
    dropped_d = dropped_q | (trigger && (state_q != StIdle));
  end

  // Status outputs.
  always_comb begin
    leds          = 8'h00;
    leds[state_q] = 1'b1;
    busy          = (state_q != StIdle);
    tx_data       = tx_data_q;
    dropped       = dropped_q;
  end

endmodule

// File: tb/tb_tx_control.sv
// tb_tx_control: scoreboard bench for tx_control. Two instances (flags byte off
// and on) share the stimulus; only the selected one is ever triggered.
module tb_tx_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trig0 = 1'b0, trig1 = 1'b0;
  logic [15:0] alu_result = 16'h0000;
  logic [4:0]  alu_flags = 5'h00;
  logic        model_busy = 1'b0, hold_busy = 1'b0;
  logic        tx_busy;
  logic        start0, start1, busy0, busy1, done0, done1, dropped0, dropped1;
  logic [7:0]  data0, data1, leds0, leds1;

  logic        start_m, start_o, busy_m, done_m, dropped_m;
  logic [7:0]  data_m, leds_m;

  bit          sel = 1'b0;
  bit          uart_en = 1'b1;
  bit          prev_start = 1'b0;
  int          checks = 0, errors = 0;
  int          starts_seen = 0, dones_seen = 0, exp_done = 0;
  int          ucnt = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  assign tx_busy = model_busy | hold_busy;

  tx_control #(.SEND_FLAGS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .trigger(trig0), .alu_result(alu_result),
    .alu_flags(alu_flags), .tx_busy(tx_busy), .tx_start(start0), .tx_data(data0),
    .busy(busy0), .done(done0), .dropped(dropped0), .leds(leds0)
  );

  tx_control #(.SEND_FLAGS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .trigger(trig1), .alu_result(alu_result),
    .alu_flags(alu_flags), .tx_busy(tx_busy), .tx_start(start1), .tx_data(data1),
    .busy(busy1), .done(done1), .dropped(dropped1), .leds(leds1)
  );

  always_comb begin
    start_m   = sel ? start1 : start0;
    start_o   = sel ? start0 : start1;
    busy_m    = sel ? busy1 : busy0;
    done_m    = sel ? done1 : done0;
    dropped_m = sel ? dropped1 : dropped0;
    data_m    = sel ? data1 : data0;
    leds_m    = sel ? leds1 : leds0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the byte stream a transfer must produce.
  function automatic void model_push(input logic [15:0] r, input logic [4:0] f, input bit sf);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
    if (sf) exp_q.push_back({3'b000, f});
  endfunction

  // UART model: busy for 10 cycles starting 2 cycles after each start.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      ucnt       = 0;
      model_busy = 1'b0;
    end else begin
      if (ucnt != 0) ucnt++;
      else if (uart_en && start_m) ucnt = 1;
      if (ucnt == 13) ucnt = 0;
      model_busy = (ucnt >= 3);
    end
  end

  // Monitor: pops the scoreboard on every start strobe and every done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      check("other_instance_start", start_o, 0);
      if (start_m) begin
        starts_seen++;
        check("start_while_busy", tx_busy, 0);
        check("start_two_cycles", prev_start, 0);
        check("start_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("tx_byte", data_m, exp_q.pop_front());
      end
      if (done_m) begin
        dones_seen++;
        check("done_expected", exp_done != 0, 1);
        check("bytes_left_at_done", exp_q.size(), 0);
        if (exp_done != 0) exp_done--;
      end
      prev_start = start_m;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    if (sel) trig1 = 1'b1;
    else trig0 = 1'b1;
    tick();
    trig0 = 1'b0;
    trig1 = 1'b0;
  endtask

  // Issue an accepted trigger; full=1 registers the whole expected stream plus done.
  task automatic send(input logic [15:0] r, input logic [4:0] f, input bit full);
    alu_result = r;
    alu_flags  = f;
    if (full) begin
      model_push(r, f, sel);
      exp_done++;
    end
    pulse();
  endtask

  task automatic wait_starts(input int target, input string name);
    int n = 0;
    while (starts_seen < target && n < 200) begin
      tick();
      n++;
    end
    check(name, starts_seen >= target, 1);
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (dones_seen < target && n < 400) begin
      tick();
      n++;
    end
    check(name, dones_seen >= target, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_leds", leds_m, 8'h01);
    check("reset_start", start_m, 0);
    check("reset_busy", busy_m, 0);
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_done = 0;
    tick();
  endtask

  initial begin
    int sb, db, hold;
    logic [15:0] r;
    logic [4:0]  f;

    // Reset values of both instances.
    tick();
    tick();
    check("rst_leds0", leds0, 8'h01);
    check("rst_leds1", leds1, 8'h01);
    check("rst_data0", data0, 8'h00);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_drop0", dropped0, 0);
    check("rst_start0", start0, 0);
    reset = 1'b0;
    tick();

    // Basic two-byte send.
    sel = 1'b0;
    sb = starts_seen;
    db = dones_seen;
    send(16'hA55A, 5'h00, 1'b1);
    alu_result = 16'h0000;
    wait_done(db + 1, "basic_done");
    check("basic_busy_fall", busy_m, 0);
    check("basic_start_count", starts_seen - sb, 2);
    check("basic_dropped", dropped_m, 0);

    // Flags byte.
    sel = 1'b1;
    db = dones_seen;
    send(16'h0100, 5'b10011, 1'b1);
    wait_done(db + 1, "flags_done");
    check("flags_busy_fall", busy_m, 0);

    // Snapshot and overlapping trigger during Wait_LSB.
    sel = 1'b0;
    sb = starts_seen;
    db = dones_seen;
    send(16'h1234, 5'h00, 1'b1);
    wait_starts(sb + 1, "overlap_first_start");
    tick();
    check("overlap_in_wait_lsb", leds_m, 8'h04);
    alu_result = 16'hFFFF;
    pulse();
    wait_done(db + 1, "overlap_done");
    check("overlap_dropped", dropped_m, 1);
    repeat (3) tick();
    check("overlap_single_done", dones_seen - db, 1);

    // UART still busy when the trigger lands.
    db = dones_seen;
    hold_busy = 1'b1;
    send(16'h6789, 5'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_start_held", start_m, 0);
      check("busy_start_leds", leds_m, 8'h02);
      tick();
    end
    hold_busy = 1'b0;
    @(negedge clk);
    check("busy_start_release", start_m, 1);
    tick();
    wait_done(db + 1, "busy_start_done");

    // Reset during Wait_MSB: no done, then a clean transfer.
    sb = starts_seen;
    db = dones_seen;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send(16'hAA55, 5'h00, 1'b0);
    wait_starts(sb + 2, "rst_mid_starts");
    repeat (3) tick();
    check("rst_mid_in_wait_msb", leds_m, 8'h10);
    do_reset();
    check("rst_mid_no_done", dones_seen, db);
    check("rst_mid_dropped", dropped_m, 0);
    send(16'hBEEF, 5'h00, 1'b1);
    wait_done(db + 1, "beef_done");

    // UART never goes busy: parked in Wait_LSB until reset.
    sel = 1'b1;
    uart_en = 1'b0;
    sb = starts_seen;
    exp_q.push_back(8'hAB);
    send(16'h00AB, 5'h1F, 1'b0);
    wait_starts(sb + 1, "stuck_start");
    repeat (40) tick();
    check("stuck_in_wait", leds_m, 8'h04);
    check("stuck_busy", busy_m, 1);
    check("stuck_single_start", starts_seen - sb, 1);
    do_reset();
    uart_en = 1'b1;

    // Randomised transfers, back-to-back where no pre-busy is requested.
    for (int i = 0; i < 12; i++) begin
      sel  = 1'($urandom_range(0, 1));
      r    = 16'($urandom);
      f    = 5'($urandom);
      hold = int'($urandom_range(0, 3));
      db   = dones_seen;
      if (hold > 0) hold_busy = 1'b1;
      send(r, f, 1'b1);
      alu_result = 16'($urandom);
      alu_flags  = 5'($urandom);
      for (int k = 1; k < hold; k++) tick();
      hold_busy = 1'b0;
      wait_done(db + 1, "rand_done");
      check("rand_busy_fall", busy_m, 0);
    end
    check("final_dropped0", dropped0, 0);
    check("final_dropped1", dropped1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
